// File: rtl/frac_pkg.sv
// Shared constants and FSM state type for the fraction reducer.
package frac_pkg;

   localparam int W_DEF = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

   localparam int CNT_W = cnt_width(W_DEF);

endpackage

// File: rtl/frac_reduce_seq_div.sv
// One restoring shift-subtract divider slice, one quotient bit per step.
// quo/rem present the values the registers will hold after the current step.
module seq_div #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] quo,
   output logic [W:0]   rem
);

   // Quotient bits shift into the dividend register as dividend bits leave it.
   logic [W-1:0] dvd_reg;
   logic [W-1:0] dsr_reg;
   logic [W:0]   rem_reg;
   logic [W:0]   rem_shift;
   logic [W:0]   rem_next;
   logic         q_bit;

   always_comb begin
      rem_shift = {rem_reg[W-1:0], dvd_reg[W-1]};
      rem_next  = rem_shift;
      q_bit     = 1'b0;
      if (rem_shift >= {1'b0, dsr_reg}) begin
         rem_next = rem_shift - {1'b0, dsr_reg};
         q_bit    = 1'b1;
      end
   end

   assign quo = {dvd_reg[W-2:0], q_bit};
   assign rem = rem_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_reg <= '0;
         dsr_reg <= '0;
         rem_reg <= '0;
      end else if (load) begin
         dvd_reg <= dividend;
         dsr_reg <= divisor;
         rem_reg <= '0;
      end else if (step) begin
         dvd_reg <= quo;
         rem_reg <= rem_next;
      end
   end

endmodule

// File: rtl/frac_reduce.sv
// Reduces a/gcd and b/gcd with two parallel sequential dividers behind
// ready/valid handshakes; flags a zero or inconsistent gcd.
module frac_reduce
   import frac_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] gcd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] num,
   output logic [W-1:0] den,
   output logic         err
);

   localparam int CW = cnt_width(W);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          accept;
   logic          load;
   logic          step;
   logic [W-1:0]  quo_a;
   logic [W-1:0]  quo_b;
   logic [W:0]    rem_a;
   logic [W:0]    rem_b;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign load     = accept && (gcd != '0);
   assign step     = (state == DIV);

   seq_div #(.W(W)) u_div_a (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .dividend (a),
      .divisor  (gcd),
      .quo      (quo_a),
      .rem      (rem_a)
   );

   seq_div #(.W(W)) u_div_b (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .step     (step),
      .dividend (b),
      .divisor  (gcd),
      .quo      (quo_b),
      .rem      (rem_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         out_valid <= 1'b0;
         num       <= '0;
         den       <= '0;
         err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (gcd == '0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     num       <= a;
                     den       <= b;
                     err       <= 1'b1;
                  end else begin
                     state <= DIV;
                     cnt   <= CW'(W - 1);
                  end
               end
            end
            DIV: begin
               cnt <= cnt - 1'b1;
               // The final step's results are captured via the lookahead outputs.
               if (cnt == '0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  num       <= quo_a;
                  den       <= quo_b;
                  err       <= (rem_a != '0) || (rem_b != '0);
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
